// File: rtl/rect_overlay_sched.sv
// rect_overlay_sched: per-frame scheduler that snapshots the head/hair/possibility
// tables on a frame start and walks them, handing one draw job at a time to the
// shared drawing engine over valid/ready.
//
// state    | meaning
// ST_IDLE  | waiting for a frame start with i_start set
// ST_SCAN  | evaluating one job (slot, kind) from the shadow tables
// ST_ISSUE | descriptor presented, waiting for the engine handshake
// ST_DONE  | walk finished, o_done pulse
module rect_overlay_sched #(
  parameter int NUM   = 8,
  parameter int P_W   = 8,
  parameter int IDX_W = 3
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  input  logic               i_start,
  input  logic               i_vs,
  input  logic [3:0]         i_thresh,
  input  logic [NUM*32-1:0]  i_head_wire,
  input  logic [NUM*32-1:0]  i_hair_wire,
  input  logic [NUM*4-1:0]   i_posi_wire,
  output logic               o_req_valid,
  input  logic               i_req_ready,
  output logic               o_kind,
  output logic [IDX_W-1:0]   o_idx,
  output logic [P_W-1:0]     o_x1,
  output logic [P_W-1:0]     o_y1,
  output logic [P_W-1:0]     o_x2,
  output logic [P_W-1:0]     o_y2,
  output logic [3:0]         o_posi,
  output logic               o_busy,
  output logic               o_done,
  output logic [IDX_W+1:0]   o_count,
  output logic               o_overrun
);
  // Job pointer: upper bits select the slot, LSB selects head (0) / hair (1).
  localparam int JW = IDX_W + 1;
  localparam logic [JW-1:0] LAST_JOB = JW'(2 * NUM - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_ISSUE, ST_DONE} state_t;

  state_t             state_q, state_d;
  logic               vs_q;
  logic [NUM*32-1:0]  head_q, hair_q;
  logic [NUM*4-1:0]   posi_q;
  logic [JW-1:0]      ptr_q, ptr_d;
  logic [IDX_W+1:0]   count_q, count_d;
  logic               overrun_q;
  logic               kind_q;
  logic [IDX_W-1:0]   idx_q;
  logic [P_W-1:0]     x1_q, y1_q, x2_q, y2_q;
  logic [3:0]         dposi_q;

  logic               vs_rise, snap, handshake, eligible, load_desc;
  logic [IDX_W-1:0]   cur_slot;
  logic               cur_kind;
  logic [31:0]        cur_word;
  logic [3:0]         cur_posi;
  logic [P_W-1:0]     cx1, cy1, cx2, cy2;

  assign vs_rise   = i_vs & ~vs_q;
  assign snap      = vs_rise & i_start;
  assign handshake = (state_q == ST_ISSUE) & i_req_ready;
  assign cur_slot  = ptr_q[JW-1:1];
  assign cur_kind  = ptr_q[0];

  // Pick the current job's box word and possibility out of the shadow tables
  always_comb begin
    cur_word = '0;
    cur_posi = '0;
    for (int k = 0; k < NUM; k++) begin
      if (cur_slot == IDX_W'(k)) begin
        cur_word = cur_kind ? hair_q[k*32 +: 32] : head_q[k*32 +: 32];
        cur_posi = posi_q[k*4 +: 4];
      end
    end
  end

  assign cx1 = cur_word[4*P_W-1 -: P_W];
  assign cy1 = cur_word[3*P_W-1 -: P_W];
  assign cx2 = cur_word[2*P_W-1 -: P_W];
  assign cy2 = cur_word[P_W-1:0];

  // Threshold is read live so a mid-frame change only affects jobs not yet scanned.
  assign eligible = (cur_posi != 4'd0) && (cur_posi >= i_thresh) &&
                    (cx2 >= cx1) && (cy2 >= cy1);

  // Next-state, job pointer and accepted-job count
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    count_d   = count_q;
    load_desc = 1'b0;
    case (state_q)
      ST_IDLE: ;
      ST_SCAN: begin
        if (eligible) begin
          load_desc = 1'b1;
          state_d   = ST_ISSUE;
        end else if (ptr_q == LAST_JOB) begin
          state_d = ST_DONE;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
      ST_ISSUE: begin
        if (i_req_ready) begin
          count_d = count_q + 1'b1;
          if (ptr_q == LAST_JOB) begin
            state_d = ST_DONE;
          end else begin
            ptr_d   = ptr_q + 1'b1;
            state_d = ST_SCAN;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // A frame start overrides the walk; a handshake on the same edge is counted
    // only if no new snapshot clears the count.
    if (snap) begin
      state_d   = ST_SCAN;
      ptr_d     = '0;
      count_d   = '0;
      load_desc = 1'b0;
    end else if (vs_rise && state_q != ST_IDLE) begin
      state_d   = ST_IDLE;
      load_desc = 1'b0;
    end
  end

  // FSM state register
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Frame-sync history and shadow copies of the rect tables
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      vs_q   <= 1'b0;
      head_q <= '0;
      hair_q <= '0;
      posi_q <= '0;
    end else begin
      vs_q <= i_vs;
      if (snap) begin
        head_q <= i_head_wire;
        hair_q <= i_hair_wire;
        posi_q <= i_posi_wire;
      end
    end
  end

  // Walk pointer, job count and overrun flag
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      ptr_q     <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      ptr_q     <= ptr_d;
      count_q   <= count_d;
      overrun_q <= vs_rise & (state_q != ST_IDLE);
    end
  end

  // Job descriptor, held stable for the whole ISSUE stall
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      kind_q  <= 1'b0;
      idx_q   <= '0;
      x1_q    <= '0;
      y1_q    <= '0;
      x2_q    <= '0;
      y2_q    <= '0;
      dposi_q <= '0;
    end else if (load_desc) begin
      kind_q  <= cur_kind;
      idx_q   <= cur_slot;
      x1_q    <= cx1;
      y1_q    <= cy1;
      x2_q    <= cx2;
      y2_q    <= cy2;
      dposi_q <= cur_posi;
    end
  end

  assign o_req_valid = (state_q == ST_ISSUE);
  assign o_busy      = (state_q != ST_IDLE);
  assign o_done      = (state_q == ST_DONE);
  assign o_count     = count_q;
  assign o_overrun   = overrun_q;
  assign o_kind      = kind_q;
  assign o_idx       = idx_q;
  assign o_x1        = x1_q;
  assign o_y1        = y1_q;
  assign o_x2        = x2_q;
  assign o_y2        = y2_q;
  assign o_posi      = dposi_q;

endmodule

// File: tb/tb_rect_overlay_sched.sv
// Self-checking bench for rect_overlay_sched: directed frames plus randomized
// tables checked against a job-list model built from the filtering rules.
module tb_rect_overlay_sched;
  localparam int NUM   = 8;
  localparam int P_W   = 8;
  localparam int IDX_W = 3;

  typedef struct packed {
    logic       kind;
    logic [2:0] idx;
    logic [7:0] x1;
    logic [7:0] y1;
    logic [7:0] x2;
    logic [7:0] y2;
    logic [3:0] posi;
  } job_t;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               i_start = 1'b0;
  logic               i_vs = 1'b0;
  logic [3:0]         i_thresh = '0;
  logic [NUM*32-1:0]  head_w = '0;
  logic [NUM*32-1:0]  hair_w = '0;
  logic [NUM*4-1:0]   posi_w = '0;
  logic               i_req_ready = 1'b0;
  logic               o_req_valid, o_kind, o_busy, o_done, o_overrun;
  logic [IDX_W-1:0]   o_idx;
  logic [P_W-1:0]     o_x1, o_y1, o_x2, o_y2;
  logic [3:0]         o_posi;
  logic [IDX_W+1:0]   o_count;

  int   checks = 0;
  int   failures = 0;
  job_t exp_q[$];
  int   exp_total;
  job_t last_acc;
  int   w_issued;

  always #5 clk = ~clk;

  rect_overlay_sched #(.NUM(NUM), .P_W(P_W), .IDX_W(IDX_W)) dut (
    .sys_clk(clk), .sys_rst(rst), .i_start(i_start), .i_vs(i_vs),
    .i_thresh(i_thresh), .i_head_wire(head_w), .i_hair_wire(hair_w),
    .i_posi_wire(posi_w), .o_req_valid(o_req_valid), .i_req_ready(i_req_ready),
    .o_kind(o_kind), .o_idx(o_idx), .o_x1(o_x1), .o_y1(o_y1), .o_x2(o_x2),
    .o_y2(o_y2), .o_posi(o_posi), .o_busy(o_busy), .o_done(o_done),
    .o_count(o_count), .o_overrun(o_overrun)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rand_box();
    logic [7:0] x1, y1, x2, y2;
    x1 = 8'($urandom_range(0, 127));
    y1 = 8'($urandom_range(0, 127));
    x2 = x1 + 8'($urandom_range(0, 127));
    y2 = y1 + 8'($urandom_range(0, 127));
    return {x1, y1, x2, y2};
  endfunction

  // Expected job list: walk slots in order, head then hair, keep those passing the filter.
  task automatic capture_model();
    exp_q.delete();
    for (int j = 0; j < 2 * NUM; j++) begin
      int s;
      logic [31:0] w;
      logic [3:0] p;
      job_t e;
      s = j / 2;
      w = (j % 2 == 1) ? hair_w[s*32 +: 32] : head_w[s*32 +: 32];
      p = posi_w[s*4 +: 4];
      e.kind = (j % 2 == 1);
      e.idx  = 3'(s);
      e.x1   = w[31:24];
      e.y1   = w[23:16];
      e.x2   = w[15:8];
      e.y2   = w[7:0];
      e.posi = p;
      if (p != 0 && p >= i_thresh && e.x2 >= e.x1 && e.y2 >= e.y1) exp_q.push_back(e);
    end
    exp_total = exp_q.size();
  endtask

  task automatic fill_random();
    for (int s = 0; s < NUM; s++) begin
      head_w[s*32 +: 32] = ($urandom_range(0, 1) == 1) ? rand_box() : $urandom;
      hair_w[s*32 +: 32] = ($urandom_range(0, 1) == 1) ? rand_box() : $urandom;
      posi_w[s*4 +: 4]   = 4'($urandom_range(0, 15));
    end
  endtask

  // mode 0 random, 1 all valid posi 15, 2 all posi 0, 3 single slot-2 job
  task automatic start_frame(input bit st, input int mode);
    @(negedge clk);
    case (mode)
      0: fill_random();
      1: for (int s = 0; s < NUM; s++) begin
           head_w[s*32 +: 32] = rand_box();
           hair_w[s*32 +: 32] = rand_box();
           posi_w[s*4 +: 4]   = 4'd15;
         end
      2: begin fill_random(); posi_w = '0; end
      default: begin
        fill_random();
        posi_w = '0;
        posi_w[2*4 +: 4]   = 4'd9;
        head_w[2*32 +: 32] = {8'd10, 8'd20, 8'd30, 8'd40};
        hair_w[2*32 +: 32] = {8'd5, 8'd5, 8'd4, 8'd9};
      end
    endcase
    i_start = st;
    i_vs    = 1'b1;
    if (st) capture_model();
  endtask

  // Follow a started frame to o_done; pct<0 means stall exactly 5 cycles per job.
  task automatic walk(input int pct, input bit scramble, input bit exp_ovr);
    int k, stalls, issued, run;
    bit got, prev_v, rdy;
    job_t prev_d, cur, e;
    k = 0; stalls = 0; issued = 0; run = 0; got = 0; prev_v = 0;
    while (!got && k < 3000) begin
      @(negedge clk);
      k++;
      i_vs = 1'b0;
      cur = {o_kind, o_idx, o_x1, o_y1, o_x2, o_y2, o_posi};
      if (k == 1) begin
        check("first_overrun", o_overrun, exp_ovr);
        check("first_busy", o_busy, 1);
        check("first_valid", o_req_valid, 0);
        check("first_count", o_count, 0);
      end
      if (scramble && k == 4) fill_random();
      if (o_done) begin
        got = 1;
      end else begin
        if (pct < 0) rdy = (run >= 5);
        else         rdy = ($urandom_range(0, 99) < pct);
        i_req_ready = rdy;
        if (o_req_valid) begin
          if (prev_v) check("desc_stable", cur, prev_d);
          if (rdy) begin
            check("job_avail", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
              e = exp_q.pop_front();
              check("job_desc", cur, e);
            end
            last_acc = cur;
            issued++;
            prev_v = 0;
            run = 0;
          end else begin
            stalls++;
            run++;
            prev_v = 1;
            prev_d = cur;
          end
        end else begin
          prev_v = 0;
          run = 0;
        end
      end
    end
    check("done_seen", got, 1);
    check("done_cycle", k, 17 + issued + stalls);
    check("jobs_left", exp_q.size(), 0);
    check("count_final", o_count, exp_total);
    @(negedge clk);
    check("done_one_cycle", o_done, 0);
    check("idle_after_done", o_busy, 0);
    w_issued = issued;
  endtask

  initial begin
    bit found, seen_done;

    repeat (3) @(negedge clk);
    check("rst_valid", o_req_valid, 0);
    check("rst_busy", o_busy, 0);
    check("rst_done", o_done, 0);
    check("rst_count", o_count, 0);
    check("rst_overrun", o_overrun, 0);
    check("rst_desc", {o_kind, o_idx, o_x1, o_y1, o_x2, o_y2, o_posi}, 0);
    rst = 1'b0;

    // no eligible jobs: 16 skipped evaluations then done
    i_thresh = 4'd0;
    start_frame(1, 2);
    walk(100, 0, 0);
    check("zero_posi_issued", w_issued, 0);

    // single eligible head box in slot 2, its hair box degenerate
    i_thresh = 4'd5;
    start_frame(1, 3);
    walk(100, 0, 0);
    check("slot2_issued", w_issued, 1);
    check("slot2_desc", last_acc, {1'b0, 3'd2, 8'd10, 8'd20, 8'd30, 8'd40, 4'd9});

    // every job eligible, 5 stall cycles per job
    i_thresh = 4'd1;
    start_frame(1, 1);
    walk(-1, 0, 0);
    check("full_issued", w_issued, 16);

    // randomized tables and ready, inputs scrambled after the snapshot
    for (int f = 0; f < 12; f++) begin
      i_thresh = 4'($urandom_range(0, 15));
      start_frame(1, 0);
      walk(60, 1, 0);
    end

    // frame start with i_start low stays idle
    start_frame(0, 0);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      i_vs = 1'b0;
      check("nostart_busy", o_busy, 0);
      check("nostart_valid", o_req_valid, 0);
    end

    // overrun: new frame start while slot 3 head is stalled
    i_thresh = 4'd1;
    start_frame(1, 1);
    found = 0;
    seen_done = 0;
    for (int c = 0; c < 200 && !found; c++) begin
      @(negedge clk);
      i_vs = 1'b0;
      if (o_done) seen_done = 1;
      if (o_req_valid && o_idx == 3'd3 && !o_kind) begin
        found = 1;
        i_req_ready = 1'b0;
      end else begin
        i_req_ready = 1'b1;
      end
    end
    check("abort_pending_found", found, 1);
    check("abort_count_before", o_count, 6);
    start_frame(1, 1);
    check("abort_still_valid", o_req_valid, 1);
    walk(50, 0, 1);
    check("abort_no_old_done", seen_done, 0);

    // async reset while a job is being issued
    start_frame(1, 1);
    found = 0;
    for (int c = 0; c < 200 && !found; c++) begin
      @(negedge clk);
      i_vs = 1'b0;
      if (o_req_valid && o_count >= 2) begin
        found = 1;
        i_req_ready = 1'b0;
      end else begin
        i_req_ready = 1'b1;
      end
    end
    check("rstmid_found", found, 1);
    rst = 1'b1;
    #1;
    check("rstmid_valid", o_req_valid, 0);
    check("rstmid_busy", o_busy, 0);
    check("rstmid_count", o_count, 0);
    @(negedge clk);
    rst = 1'b0;
    seen_done = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (o_done || o_busy) seen_done = 1;
    end
    check("rstmid_stays_idle", seen_done, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
